// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta 1-bit DAC: the accumulator carry is the output pulse,
// so the ones-density of dac_out equals dac_in / 2^(RES+1).
module sigma_delta_dac #(
    parameter int RES = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [RES:0] dac_in,
    output logic         dac_out
);

    localparam int W = RES + 1;

    logic [W-1:0] acc;
    logic [W:0]   sum;

    // Full-width add so the carry is taken before any truncation; the
    // remainder is the residual error carried into the next cycle.
    assign sum = {1'b0, acc} + {1'b0, dac_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            acc     <= sum[W-1:0];
            dac_out <= sum[W];
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Self-checking bench for sigma_delta_dac: vector table, corner-case sequences,
// code sweep and random codes against an unbounded running-sum reference model.
module tb_sigma_delta_dac;

    localparam int RES = 7;
    localparam longint M = 64'd1 << (RES + 1);

    logic         clk;
    logic         reset;
    logic [RES:0] dac_in;
    logic         dac_out;

    int     passed = 0;
    int     total  = 0;
    longint msum   = 0;

    sigma_delta_dac #(.RES(RES)) dut (
        .clk     (clk),
        .reset   (reset),
        .dac_in  (dac_in),
        .dac_out (dac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RES:0] code;
        int           edge_n;
        logic         exp_out;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: the output pulses whenever the total of all codes since reset
    // crosses another multiple of 2^(RES+1).
    task automatic tick(input logic [RES:0] code, output logic o);
        longint prev;
        dac_in = code;
        @(posedge clk);
        #1;
        o    = dac_out;
        prev = msum;
        msum = msum + longint'(code);
        check("model", longint'(o), longint'((msum / M) != (prev / M)));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        msum  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic count_ones(input logic [RES:0] code, input int n, output int ones);
        logic o;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick(code, o);
            if (o) ones++;
        end
    endtask

    initial begin
        vec_t   vecs[$];
        logic   o;
        int     ones;
        int     first_pos;
        int     last_pos;
        logic   ref_seq[64];
        logic [RES:0] rc;
        int     hold;

        reset  = 1'b0;
        dac_in = '1;

        // Reset hold with a full-scale code present
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold_out", longint'(dac_out), 0);
            check("reset_hold_acc", longint'(dut.acc), 0);
        end

        // Table: output at edge k after release for a constant code
        vecs.push_back('{8'h01, 1,   1'b0});
        vecs.push_back('{8'h01, 255, 1'b0});
        vecs.push_back('{8'h01, 256, 1'b1});
        vecs.push_back('{8'h80, 1,   1'b0});
        vecs.push_back('{8'h80, 2,   1'b1});
        vecs.push_back('{8'h80, 3,   1'b0});
        vecs.push_back('{8'hFF, 1,   1'b0});
        vecs.push_back('{8'hFF, 2,   1'b1});
        vecs.push_back('{8'hFF, 256, 1'b1});
        vecs.push_back('{8'hFF, 257, 1'b0});
        vecs.push_back('{8'h03, 85,  1'b0});
        vecs.push_back('{8'h03, 86,  1'b1});
        vecs.push_back('{8'h00, 300, 1'b0});
        foreach (vecs[v]) begin
            do_reset();
            for (int k = 0; k < vecs[v].edge_n; k++) tick(vecs[v].code, o);
            check($sformatf("vec%0d_code%0h_edge%0d", v, vecs[v].code, vecs[v].edge_n),
                  longint'(o), longint'(vecs[v].exp_out));
        end

        // Asynchronous assertion drops the output between edges
        do_reset();
        tick(8'hFF, o);
        tick(8'hFF, o);
        check("async_pre_out", longint'(dac_out), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_drop_out", longint'(dac_out), 0);
        check("async_drop_acc", longint'(dut.acc), 0);

        // Code 1: four ones in 1024 cycles, 256 apart
        do_reset();
        ones = 0; first_pos = -1; last_pos = -1;
        for (int k = 1; k <= 1024; k++) begin
            tick(8'h01, o);
            if (o) begin
                if (last_pos >= 0) check("code01_spacing", k - last_pos, 256);
                if (first_pos < 0) first_pos = k;
                last_pos = k;
                ones++;
            end
        end
        check("code01_ones", ones, 4);
        check("code01_first", first_pos, 256);

        // Code 0x80: alternating, 128 per window
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(8'h80, o);
            check("code80_alt", longint'(o), longint'(k % 2 == 0));
        end
        count_ones(8'h80, 256, ones);
        check("code80_ones", ones, 128);

        // Code 0xFF: 255 per window; code 0: silent
        do_reset();
        count_ones(8'hFF, 256, ones);
        check("codeFF_ones", ones, 255);
        do_reset();
        count_ones(8'h00, 512, ones);
        check("code00_ones", ones, 0);

        // Sweep with no intervening reset: residual carries across code changes
        do_reset();
        for (int c = 0; c < 256; c++) begin
            count_ones(c[RES:0], 256, ones);
            check($sformatf("sweep_%0d", c), ones, c);
        end

        // Mid-stream reset reproduces the post-reset sequence
        do_reset();
        for (int k = 0; k < 64; k++) begin
            tick(8'h55, o);
            ref_seq[k] = o;
        end
        count_ones(8'h55, 37, ones);
        #3;
        reset = 1'b0;
        msum  = 0;
        @(posedge clk);
        #1;
        check("midreset_out", longint'(dac_out), 0);
        reset = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick(8'h55, o);
            check($sformatf("midreset_seq_%0d", k), longint'(o), longint'(ref_seq[k]));
        end

        // Random codes with random hold lengths
        do_reset();
        rc = '0;
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                rc   = RES'($urandom_range(0, int'(M) - 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            tick(rc, o);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
